// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 fetch stage: datapath width, reset vector and FSM states.
package lc3_pkg;

    localparam int unsigned XLEN = 16;
    localparam logic [XLEN-1:0] LC3_RESET_PC = 16'h3000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/lc3_fetch_unit.sv
// LC-3 instruction fetch: owns fetch_pc, drives a req/ack imem port and hands one
// instruction at a time to decode; execute redirects squash any fetch already in flight.
module lc3_fetch_unit
    import lc3_pkg::*;
#(
    parameter int unsigned     XLEN     = lc3_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = LC3_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            br,
    input  logic [XLEN-1:0] br_pc,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    fetch_state_t    state, state_d;
    logic [XLEN-1:0] fetch_pc, fetch_pc_d;
    logic            squash, squash_d;
    logic            mem_req_d;
    logic [XLEN-1:0] mem_addr_d;
    logic            inst_valid_d;
    logic [XLEN-1:0] inst_d, inst_pc_d;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            squash     <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= RESET_PC;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= RESET_PC;
        end else begin
            state      <= state_d;
            fetch_pc   <= fetch_pc_d;
            squash     <= squash_d;
            mem_req    <= mem_req_d;
            mem_addr   <= mem_addr_d;
            inst_valid <= inst_valid_d;
            inst       <= inst_d;
            inst_pc    <= inst_pc_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state;
        fetch_pc_d   = fetch_pc;
        squash_d     = squash;
        inst_valid_d = inst_valid;
        inst_d       = inst;
        inst_pc_d    = inst_pc;

        unique case (state)
            IDLE: begin
                state_d = REQ;
                if (br) fetch_pc_d = br_pc;
            end
            REQ: begin
                if (!mem_ack) begin
                    if (br) begin
                        squash_d   = 1'b1;
                        fetch_pc_d = br_pc;
                    end
                end else if (squash || br) begin
                    // Stale word: drop it and re-request from the redirected PC.
                    squash_d = 1'b0;
                    if (br) fetch_pc_d = br_pc;
                end else begin
                    inst_d       = mem_rdata;
                    inst_pc_d    = fetch_pc;
                    inst_valid_d = 1'b1;
                    fetch_pc_d   = fetch_pc + XLEN'(1);
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (br) begin
                    inst_valid_d = 1'b0;
                    fetch_pc_d   = br_pc;
                    state_d      = REQ;
                end else if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    state_d      = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        // Address is frozen while a request is outstanding, otherwise it tracks fetch_pc.
        mem_req_d  = (state_d == REQ);
        mem_addr_d = (state == REQ && !mem_ack) ? mem_addr : fetch_pc_d;
    end

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Directed bench for lc3_fetch_unit: hand-computed vectors checked with immediate assertions.
module tb_lc3_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        br;
    logic [15:0] br_pc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst;
    logic [15:0] inst_pc;

    int          vectors = 0;
    int          miscompares = 0;
    int          xfer_count = 0;
    logic [15:0] last_acc = 16'h0000;
    logic        seen_beef = 1'b0;

    always #5 clk = ~clk;

    lc3_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .br         (br),
        .br_pc      (br_pc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc)
    );

    // Decode-side observer: count handshakes and watch for the squashed word
    always @(posedge clk) begin
        if (!rst && inst_valid && inst_ready) begin
            xfer_count = xfer_count + 1;
            last_acc   = inst;
        end
        if (inst == 16'hBEEF) seen_beef = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors = vectors + 1;
        assert (obs === exp)
        else begin
            miscompares = miscompares + 1;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        br         = 1'b0;
        br_pc      = 16'h0000;
        mem_ack    = 1'b0;
        mem_rdata  = 16'h0000;
        inst_ready = 1'b0;
        step();
        step();
        chk("rst_mem_req",    16'(mem_req), 16'h0000);
        chk("rst_mem_addr",   mem_addr, 16'h3000);
        chk("rst_inst_valid", 16'(inst_valid), 16'h0000);
        chk("rst_inst",       inst, 16'h0000);
        chk("rst_inst_pc",    inst_pc, 16'h3000);

        // 1: first fetch after reset, ack one cycle after request
        rst = 1'b0;
        step();
        chk("t1_req",  16'(mem_req), 16'h0001);
        chk("t1_addr", mem_addr, 16'h3000);
        step();
        chk("t1_req_wait",  16'(mem_req), 16'h0001);
        chk("t1_valid_low", 16'(inst_valid), 16'h0000);
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        step();
        mem_ack = 1'b0;
        chk("t1_valid",   16'(inst_valid), 16'h0001);
        chk("t1_inst",    inst, 16'h1234);
        chk("t1_inst_pc", inst_pc, 16'h3000);
        chk("t1_req_off", 16'(mem_req), 16'h0000);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("t1_valid_drop", 16'(inst_valid), 16'h0000);
        chk("t1_next_req",   16'(mem_req), 16'h0001);
        chk("t1_next_addr",  mem_addr, 16'h3001);
        chk("t1_xfer",       16'(xfer_count), 16'h0001);
        chk("t1_acc",        last_acc, 16'h1234);

        // 2: decode stalls for 5 cycles while HOLDing
        mem_ack = 1'b1; mem_rdata = 16'hA001;
        step();
        mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_inst",  inst, 16'hA001);
            chk("t2_hold_pc",    inst_pc, 16'h3001);
            chk("t2_hold_req",   16'(mem_req), 16'h0000);
            chk("t2_hold_valid", 16'(inst_valid), 16'h0001);
            step();
        end
        chk("t2_xfer_none", 16'(xfer_count), 16'h0001);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("t2_xfer", 16'(xfer_count), 16'h0002);
        chk("t2_acc",  last_acc, 16'hA001);
        chk("t2_addr", mem_addr, 16'h3002);

        // 3: redirect while holding an unaccepted instruction
        mem_ack = 1'b1; mem_rdata = 16'hB002;
        step();
        mem_ack = 1'b0;
        chk("t3_inst", inst, 16'hB002);
        br = 1'b1; br_pc = 16'h4000;
        step();
        br = 1'b0;
        chk("t3_valid_drop", 16'(inst_valid), 16'h0000);
        chk("t3_req",        16'(mem_req), 16'h0001);
        chk("t3_addr",       mem_addr, 16'h4000);
        chk("t3_no_xfer",    16'(xfer_count), 16'h0002);
        mem_ack = 1'b1; mem_rdata = 16'hC400;
        step();
        mem_ack = 1'b0;
        chk("t3_new_inst", inst, 16'hC400);
        chk("t3_new_pc",   inst_pc, 16'h4000);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("t3_acc",     last_acc, 16'hC400);
        chk("t3_addr_nx", mem_addr, 16'h4001);

        // 4: redirect during an outstanding request, ack 3 cycles later
        br = 1'b1; br_pc = 16'h5000;
        step();
        br = 1'b0;
        chk("t4_addr_held", mem_addr, 16'h4001);
        chk("t4_req_held",  16'(mem_req), 16'h0001);
        step();
        chk("t4_addr_held2", mem_addr, 16'h4001);
        step();
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        step();
        mem_ack = 1'b0;
        chk("t4_squash_valid", 16'(inst_valid), 16'h0000);
        chk("t4_req",          16'(mem_req), 16'h0001);
        chk("t4_addr",         mem_addr, 16'h5000);
        mem_ack = 1'b1; mem_rdata = 16'hD500;
        step();
        mem_ack = 1'b0;
        chk("t4_inst",    inst, 16'hD500);
        chk("t4_inst_pc", inst_pc, 16'h5000);
        chk("t4_no_beef", 16'(seen_beef), 16'h0000);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;

        // 5: fetch_pc wraps from FFFF to 0000
        mem_ack = 1'b1; mem_rdata = 16'hE501;
        step();
        mem_ack = 1'b0;
        br = 1'b1; br_pc = 16'hFFFF;
        step();
        br = 1'b0;
        chk("t5_addr", mem_addr, 16'hFFFF);
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        step();
        mem_ack = 1'b0;
        chk("t5_pc_ffff", inst_pc, 16'hFFFF);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("t5_addr_wrap", mem_addr, 16'h0000);
        mem_ack = 1'b1; mem_rdata = 16'h2222;
        step();
        mem_ack = 1'b0;
        chk("t5_pc_0000", inst_pc, 16'h0000);
        chk("t5_inst",    inst, 16'h2222);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("t5_xfer", 16'(xfer_count), 16'h0006);
        chk("t5_acc",  last_acc, 16'h2222);

        // 6: reset mid-request, late ack must be ignored
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_req",   16'(mem_req), 16'h0000);
        chk("t6_rst_valid", 16'(inst_valid), 16'h0000);
        chk("t6_rst_addr",  mem_addr, 16'h3000);
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        step();
        mem_ack = 1'b0;
        chk("t6_ignored_valid", 16'(inst_valid), 16'h0000);
        chk("t6_ignored_inst",  inst, 16'h0000);
        chk("t6_refetch_req",   16'(mem_req), 16'h0001);
        chk("t6_refetch_addr",  mem_addr, 16'h3000);
        mem_ack = 1'b1; mem_rdata = 16'h3333;
        step();
        mem_ack = 1'b0;
        chk("t6_inst",    inst, 16'h3333);
        chk("t6_inst_pc", inst_pc, 16'h3000);
        chk("t6_valid",   16'(inst_valid), 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
